// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-memory line adapter.
package cache_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned BEATS    = LINE_W / BEAT_W;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP
    } adapter_state_t;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache dfp port plus banked-memory burst port, as seen by the line adapter.
interface cacheline_adapter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
);

    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    // The adapter: responder on dfp, initiator on bmem.
    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    // The surroundings: cache on dfp, memory on bmem.
    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

endinterface

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line reads/writes into 4-beat 64-bit bmem bursts,
// answering each request with a single dfp_resp pulse.
module cacheline_adapter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = cache_pkg::LINE_W,
    parameter int unsigned BEAT_W = cache_pkg::BEAT_W
) (
    input  logic clk,
    input  logic rst,
    cacheline_adapter_if.slave bus
);

    import cache_pkg::*;

    localparam int unsigned NBEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(LINE_W);

    adapter_state_t    state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] line_next;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  lo;
    logic              resp_q;
    logic              req_ok;
    logic              beat_ok;
    logic              last_beat;

    // resp_q masks the request the cache is still holding right after RESP.
    always_comb begin
        req_ok    = !resp_q && (bus.dfp_read || bus.dfp_write);
        beat_ok   = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
        last_beat = (cnt == CNT_W'(NBEATS - 1));
        lo        = IDX_W'(cnt) * IDX_W'(BEAT_W);
        line_next = data_q;
        line_next[lo +: BEAT_W] = bus.bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_ok) state_next = bus.dfp_read ? RD_REQ : WR_DATA;
            RD_REQ:  if (bus.bmem_ready) state_next = RD_DATA;
            RD_DATA: if (beat_ok && last_beat) state_next = RESP;
            WR_DATA: if (bus.bmem_ready && last_beat) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // data_q holds the write line, or the partially assembled read line.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            cnt     <= '0;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= (state == RESP);
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        addr_q <= {bus.dfp_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                        cnt    <= '0;
                        if (!bus.dfp_read) data_q <= bus.dfp_wdata;
                    end
                end
                RD_REQ: begin
                    if (bus.bmem_ready) cnt <= '0;
                end
                RD_DATA: begin
                    if (beat_ok) begin
                        data_q <= line_next;
                        cnt    <= cnt + 1'b1;
                        if (last_beat) rdata_q <= line_next;
                    end
                end
                WR_DATA: begin
                    if (bus.bmem_ready) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.bmem_read  = (state == RD_REQ);
    assign bus.bmem_write = (state == WR_DATA);
    assign bus.dfp_resp   = (state == RESP);
    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_wdata = data_q[lo +: BEAT_W];
    assign bus.dfp_rdata  = rdata_q;

    // Simultaneous read and write is illegal; read is served.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && !resp_q)
            assert (!(bus.dfp_read && bus.dfp_write));
    end

endmodule
